uart_tx_serializer: RTL and testbench

//  Drains bytes from the UART TX FIFO and shifts them out on the serial line as 8N1/8E1/8O1 frames.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx_serializer.sv | 112 +++++++++++
 tb/tb_uart_tx_serializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX state encoding and frame constants.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: baud_cnt runs 0..CLKS_PER_BIT-1 and bit_tick marks the last cycle of each bit.
// Shared by the TX serializer and the RX deserializer.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clr,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_cnt;

    // clr holds the counter at zero so the first bit after it is a full period
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn)
            baud_cnt <= '0;
        else if (clr || bit_tick)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 1'b1;
    end

    assign bit_tick = (baud_cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Pops bytes from the TX FIFO and sends them as start/8 data/[parity]/stop frames on tx.
// Build option: define UART_TX_PARITY_EN to insert the parity bit (PARITY_ODD selects odd/even).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic [7:0] fifo_dataOut,
    input  logic       fifo_Empty,
    output logic       fifo_readEn,
    output logic       tx,
    output logic       tx_busy
);

    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_tx_serializer: illegal parameter value");
    end

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2);
`ifdef UART_TX_PARITY_EN
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);
`endif

    uart_tx_state_t state, next_state;
    logic           bit_tick;
    logic [7:0]     shift_reg;
    logic [2:0]     bit_cnt;
    logic [2:0]     data_idx;
    logic           stop_cnt;
    logic           tx_next;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clr     ((state == IDLE) || (state == LOAD)),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_Empty) next_state = LOAD;
            LOAD:    next_state = START;
            START:   if (bit_tick) next_state = DATA;
            DATA: begin
                if (bit_tick && bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY:  if (bit_tick) next_state = STOP;
`endif
            STOP:    if (bit_tick && stop_cnt == STOP_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The byte is kept whole (indexed, not shifted) so parity can be taken over all of it
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            tx        <= UART_IDLE_LEVEL;
        end else begin
            tx <= tx_next;
            if (state == LOAD) begin
                shift_reg <= fifo_dataOut;
                bit_cnt   <= '0;
                stop_cnt  <= 1'b0;
            end else if (bit_tick) begin
                if (state == DATA) bit_cnt  <= bit_cnt + 3'd1;
                if (state == STOP) stop_cnt <= ~stop_cnt;
            end
        end
    end

    // tx_next is the level for the coming state, so the tx flop lines up with state
    always_comb begin
        fifo_readEn = (state == IDLE) && !fifo_Empty && !PRESETn;
        tx_busy     = (state != IDLE);
        data_idx    = (state == DATA && bit_tick) ? bit_cnt + 3'd1 : bit_cnt;
        case (next_state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg[data_idx];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = (^shift_reg) ^ PAR_ODD;
`endif
            default: tx_next = UART_IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer (CLKS_PER_BIT=4, STOP_BITS=1, PARITY_ODD=0).
// Expected frames follow the UART_TX_PARITY_EN build option.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [10:0] frame;
        bit          b2b;
    } exp_t;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b1;
    logic [7:0] fifo_dataOut = 8'h00;
    logic       fifo_Empty = 1'b1;
    logic       fifo_readEn;
    logic       tx;
    logic       tx_busy;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];

    int n_compared = 0;
    int n_failed   = 0;
    int frames_done = 0;
    int cyc = 0;
    int readen_cnt = 0;
    int busy_cnt = 0;
    int txlow_cnt = 0;
    int bad_pop = 0;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (1),
        .PARITY_ODD  (0)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .fifo_dataOut(fifo_dataOut),
        .fifo_Empty  (fifo_Empty),
        .fifo_readEn (fifo_readEn),
        .tx          (tx),
        .tx_busy     (tx_busy)
    );

    always #5 PCLK = ~PCLK;

    // FIFO model: registered read data, empty flag follows the queue
    always @(posedge PCLK) begin
        if (fifo_readEn && fifo_q.size() > 0)
            fifo_dataOut <= fifo_q.pop_front();
        fifo_Empty <= (fifo_q.size() == 0);
        cyc <= cyc + 1;
    end

    always @(negedge PCLK) begin
        if (fifo_readEn) readen_cnt <= readen_cnt + 1;
        if (tx_busy) busy_cnt <= busy_cnt + 1;
        if (tx == 1'b0) txlow_cnt <= txlow_cnt + 1;
        if (fifo_readEn && fifo_Empty) bad_pop <= bad_pop + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic [9:0] frame_np,
                                 input logic [10:0] frame_p, input bit expect_frame,
                                 input bit b2b);
        exp_t e;
`ifdef UART_TX_PARITY_EN
        e.frame = frame_p;
`else
        e.frame = {1'b0, frame_np};
`endif
        e.b2b = b2b;
        fifo_q.push_back(data);
        if (expect_frame) exp_q.push_back(e);
    endtask

    task automatic waitFrames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput(name, 32'(frames_done >= target), 32'd1);
    endtask

    // Monitor: captures each frame cycle by cycle from the start bit and scores it
    initial begin
        bit          in_frame = 0;
        bit          steady = 1;
        int          pos = 0;
        int          last_end = -1000;
        logic [10:0] got = '0;
        exp_t        e;
        forever begin
            @(negedge PCLK);
            if (PRESETn) begin
                in_frame = 0;
                continue;
            end
            if (!in_frame && tx == 1'b0) begin
                in_frame = 1;
                pos = 0;
                steady = 1;
                got = '0;
                if (exp_q.size() > 0 && exp_q[0].b2b)
                    checkOutput("b2b_gap", 32'(cyc - last_end - 1), 32'd2);
            end
            if (in_frame) begin
                if (pos % CPB == 0)
                    got[pos / CPB] = tx;
                else if (tx !== got[pos / CPB])
                    steady = 0;
                if (tx_busy !== 1'b1) steady = 0;
                pos++;
                if (pos == NB * CPB) begin
                    in_frame = 0;
                    last_end = cyc;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_frame", {21'd0, got}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("frame_bits", {20'd0, steady, got}, {20'd0, 1'b1, e.frame});
                    end
                    frames_done++;
                end
            end
        end
    end

    initial begin
        int r0, b0, t0, f0, n;

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            checkOutput("reset_tx", 32'(tx), 32'd1);
            checkOutput("reset_readen", 32'(fifo_readEn), 32'd0);
            checkOutput("reset_busy", 32'(tx_busy), 32'd0);
        end
        #1 PRESETn = 1'b0;

        // Empty FIFO: nothing happens
        @(negedge PCLK);
        r0 = readen_cnt; b0 = busy_cnt; t0 = txlow_cnt;
        repeat (100) @(negedge PCLK);
        checkOutput("empty_readen", 32'(readen_cnt - r0), 32'd0);
        checkOutput("empty_busy", 32'(busy_cnt - b0), 32'd0);
        checkOutput("empty_txlow", 32'(txlow_cnt - t0), 32'd0);

        // Single 0xA5
        r0 = readen_cnt; b0 = busy_cnt; f0 = frames_done;
        applyStimulus(8'hA5, 10'b1_10100101_0, 11'b1_0_10100101_0, 1, 0);
        waitFrames(f0 + 1, 200, "a5_timeout");
        repeat (5) @(negedge PCLK);
        checkOutput("a5_readen", 32'(readen_cnt - r0), 32'd1);
        checkOutput("a5_busy", 32'(busy_cnt - b0), 32'(1 + NB * CPB));

        // Back-to-back 0x00 then 0xFF
        r0 = readen_cnt; b0 = busy_cnt; f0 = frames_done;
        applyStimulus(8'h00, 10'b1_00000000_0, 11'b1_0_00000000_0, 1, 0);
        applyStimulus(8'hFF, 10'b1_11111111_0, 11'b1_0_11111111_0, 1, 1);
        waitFrames(f0 + 2, 400, "b2b_timeout");
        repeat (5) @(negedge PCLK);
        checkOutput("b2b_readen", 32'(readen_cnt - r0), 32'd2);
        checkOutput("b2b_busy", 32'(busy_cnt - b0), 32'(2 * (1 + NB * CPB)));

        // 0x07: parity bit 1 when enabled
        r0 = readen_cnt; b0 = busy_cnt; f0 = frames_done;
        applyStimulus(8'h07, 10'b1_00000111_0, 11'b1_1_00000111_0, 1, 0);
        waitFrames(f0 + 1, 200, "p07_timeout");
        repeat (5) @(negedge PCLK);
        checkOutput("p07_readen", 32'(readen_cnt - r0), 32'd1);
        checkOutput("p07_busy", 32'(busy_cnt - b0), 32'(1 + NB * CPB));

        // 0x5A aborted by reset during data bit 3
        applyStimulus(8'h5A, 10'b1_01011010_0, 11'b1_0_01011010_0, 0, 0);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("abort_start_seen", 32'(tx), 32'd0);
        repeat (18) @(negedge PCLK);
        checkOutput("abort_busy_before", 32'(tx_busy), 32'd1);
        #1 PRESETn = 1'b1;
        #1;
        checkOutput("abort_tx", 32'(tx), 32'd1);
        checkOutput("abort_busy", 32'(tx_busy), 32'd0);
        @(negedge PCLK);
        #1 PRESETn = 1'b0;
        @(negedge PCLK);
        r0 = readen_cnt; b0 = busy_cnt; t0 = txlow_cnt;
        repeat (60) @(negedge PCLK);
        checkOutput("abort_readen", 32'(readen_cnt - r0), 32'd0);
        checkOutput("abort_busy_after", 32'(busy_cnt - b0), 32'd0);
        checkOutput("abort_txlow", 32'(txlow_cnt - t0), 32'd0);

        checkOutput("pop_while_empty", 32'(bad_pop), 32'd0);
        checkOutput("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
